lab9_button_conditioner: RTL
============================

# lab9_button_conditioner

Conditions the raw push-button inputs before they reach the button PIO port, which sees only clean levels. Each channel gets a two-flop synchronizer, a counter-based debouncer and edge detection. The block drives the PIO `in_port` bus with debounced, active-high levels and provides one-cycle press/release pulses for local fabric logic. It sits between the board KEY pins and the button PIO.

## Interface
Parameters:
- `WIDTH`, default 2: number of button channels; must be ≥1.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples required to accept a change (10 ms at 50 MHz); must be ≥1.
- `ACTIVE_LOW`, default 1: 1 means a raw input of 0 is "pressed" (board KEY polarity).

Ports:
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `btn_raw`, input, WIDTH: asynchronous board button pins.
- `btn_level`, output, WIDTH: debounced level, 1 = pressed; feeds the PIO `in_port`.
- `btn_press`, output, WIDTH: one-cycle pulse on an accepted press.
- `btn_release`, output, WIDTH: one-cycle pulse on an accepted release.

## Operation
- **Synchronizer:** two flops per channel (`sync1`, `sync2`). Both reset to the released raw value (1 if `ACTIVE_LOW`, else 0), so reset never produces a spurious press.
- **Normalized sample:** `pressed = ACTIVE_LOW ? ~sync2 : sync2`.
- **Per-channel FSM,** four states:
  - `RELEASED`: if `pressed`, go to `PRESS_WAIT` with cnt=0.
  - `PRESS_WAIT`:
    - If `!pressed`, return to `RELEASED` with cnt=0 (bounce rejected).
    - Else, if cnt == DEBOUNCE_CYCLES-1, go to `PRESSED`.
    - Else, cnt++.
  - `PRESSED`: if `!pressed`, go to `RELEASE_WAIT` with cnt=0.
  - `RELEASE_WAIT`: mirror of `PRESS_WAIT`. `pressed` returns to `PRESSED`; count completion goes to `RELEASED`.
- **Counter:**
  - Width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - It never wraps; it is only compared for equality with DEBOUNCE_CYCLES-1.
  - It is cleared on every state entry.
- **Outputs:**
  - `btn_level` = 1 in `PRESSED` and `RELEASE_WAIT`; 0 otherwise. It is registered and derived directly from state.
  - `btn_press` is registered; asserted for exactly one cycle on the `PRESS_WAIT`→`PRESSED` transition.
  - `btn_release` is registered; asserted for exactly one cycle on the `RELEASE_WAIT`→`RELEASED` transition.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- **Pulse exclusivity:** `btn_press` and `btn_release` are never both high on one channel in the same cycle.
- **Reset mid-operation:** all FSMs go to `RELEASED`, cnt=0, and every output goes to 0 immediately (asynchronous). No pulse is generated on reset release, even if the button is held. A held button is accepted as a new press after the full latency.

## Timing
- **Reset values:** `btn_level`=0, `btn_press`=0, `btn_release`=0; FSM state `RELEASED`; `sync1`/`sync2` at the released value.
- **Latency:** with the raw input changing before clock edge 1 and then held stable:
  - `sync2` updates at edge 2.
  - The FSM enters the wait state at edge 3.
  - `btn_level` changes and the pulse asserts at edge 3+DEBOUNCE_CYCLES.
  - The pulse deasserts at the next edge.
- **Bounce rejection:** any reversal of the synchronized sample before the count completes restarts the wait from the opposite state. Bursts shorter than DEBOUNCE_CYCLES cycles never change `btn_level`.
- **Downstream:** `btn_level` is glitch-free, changes at most once per DEBOUNCE_CYCLES+1 cycles per channel, and is safe to sample directly by the PIO each clock.

## Structure
- **Package `lab9_button_pkg`:** state enum `btn_state_t` (`RELEASED`, `PRESS_WAIT`, `PRESSED`, `RELEASE_WAIT`) and a function computing the counter width from DEBOUNCE_CYCLES.
- **Sub-module `lab9_button_channel`:** one channel containing the synchronizer, FSM, counter and the three registered outputs, parameterized by `DEBOUNCE_CYCLES` and `ACTIVE_LOW`.
- **Top level:** a generate loop over `WIDTH` instances of `lab9_button_channel`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8, ACTIVE_LOW=1, WIDTH=2.
- **Reset:** hold reset_n=0 with `btn_raw`=2'b11 → all outputs 0. Release reset; hold `btn_raw` 2'b11 for 50 cycles → no pulses.
- **Clean press:** `btn_raw[0]` 1→0 and held → `btn_level[0]`=1 and `btn_press[0]` high for exactly 1 cycle at edge 11. Channel 1 stays at 0.
- **Bounce:** `btn_raw[0]` toggles with a period of 6 cycles (low 3, high 3) for 60 cycles, then stays high → `btn_level[0]` stays 0 and no pulses occur.
- **Release with bounce:** from pressed, go high 5 cycles, low 2, then high and held → `btn_release[0]` pulses once, 11 edges after the final rising raw edge.
- **Simultaneous channels:** both channels pressed on the same cycle → `btn_press`=2'b11 for one cycle at edge 11, and `btn_level`=2'b11 thereafter.
- **Reset mid-operation:** assert reset_n=0 mid-`PRESS_WAIT` on channel 1, and again while channel 0 is `PRESSED` → outputs 0 at once. After reset, with the button held, `btn_press` pulses 11 edges after reset release.

Source files
------------

// File: rtl/lab9_button_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lab9_button_pkg
//  Purpose  : Shared types and helpers for the push-button conditioner.
//             Provides the per-channel debounce state encoding and the
//             debounce counter width calculation.
//  Contents : btn_state_t  - debounce FSM state
//             cnt_width()  - counter width for a given DEBOUNCE_CYCLES
//  Revision : 1.0 - initial release
// ============================================================================
package lab9_button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Bits needed to hold the values 0..cycles. Never returns less than 1 so a
  // single-cycle debounce still gets a legal vector.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lab9_button_channel.sv
`default_nettype none
// ============================================================================
//  Module   : lab9_button_channel
//  Purpose  : One push-button channel: two-flop synchronizer, counter-based
//             debounce FSM and registered level / press / release outputs.
//  Ports    : clk         - system clock
//             reset_n     - asynchronous active-low reset
//             btn_raw     - asynchronous button pin
//             btn_level   - debounced level, 1 = pressed
//             btn_press   - one-cycle pulse on accepted press
//             btn_release - one-cycle pulse on accepted release
//  Revision : 1.0 - initial release
// ============================================================================
module lab9_button_channel
  import lab9_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Raw pin value while the button is not pressed; the synchronizer resets
  // here so releasing reset never looks like a press edge.
  localparam logic            RAW_IDLE = ACTIVE_LOW;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             pressed;

  assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      RELEASED: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase

    // Level follows the next state so it changes on the same edge as the pulse.
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= RAW_IDLE;
      sync2_q   <= RAW_IDLE;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

`default_nettype wire

// File: rtl/lab9_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : lab9_button_conditioner
//  Purpose  : Conditions WIDTH raw board buttons into clean, debounced,
//             active-high levels for the button PIO plus one-cycle
//             press/release pulses for local logic.
//  Ports    : clk         - system clock
//             reset_n     - asynchronous active-low reset
//             btn_raw     - [WIDTH] asynchronous button pins
//             btn_level   - [WIDTH] debounced level, 1 = pressed (PIO in_port)
//             btn_press   - [WIDTH] one-cycle pulse on accepted press
//             btn_release - [WIDTH] one-cycle pulse on accepted release
//  Revision : 1.0 - initial release
// ============================================================================
module lab9_button_conditioner
  import lab9_button_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_channel
    lab9_button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_channel (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

`default_nettype wire
